// File: rtl/pio_sensor_in_if.sv
// Avalon-MM slave bus bundle for the sensor input PIO.
// Zero-latency reads: readdata and irq are driven combinationally by the slave.
// No backpressure: the slave accepts every transfer without wait states.
interface pio_sensor_in_if #(
    parameter int WIDTH = 5
) ();
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;
    logic             irq;

    // CPU / interconnect side
    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata, irq
    );

    // PIO side
    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata, irq
    );
endinterface

// File: rtl/pio_sensor_in.sv
// Input PIO: synchronizes and debounces external bits, captures edges, maskable irq (MASK/irq need PIO_IRQ_EN).
// Latency: in_port change at edge k reaches DATA after edge k+1+DEBOUNCE_CYCLES; capture/irq one edge later.
// No backpressure: zero wait states, readdata muxed on address only.
module pio_sensor_in #(
    parameter int               WIDTH           = 5,
    parameter int               DEBOUNCE_CYCLES = 16,
    parameter int               EDGE_TYPE       = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] in_port,
    pio_sensor_in_if.slave   bus
);

    localparam int             CW   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0]  LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_d;
    logic [CW-1:0]    cnt [WIDTH];
    logic [WIDTH-1:0] edge_capture;
    logic [WIDTH-1:0] ev;
    logic [WIDTH-1:0] clr;
    logic             wr;

    assign wr  = bus.chipselect & ~bus.write_n;
    assign clr = (wr && bus.address == 2'd3) ? bus.writedata : '0;

    // Two-flop synchronizer for the asynchronous inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= RESET_VALUE;
            sync2 <= RESET_VALUE;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: flip only after DEBOUNCE_CYCLES consecutive mismatches; any match restarts the count.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            deb <= RESET_VALUE;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    // Delayed copy for edge detection; reset alongside deb so reset release never looks like an edge.
    always_ff @(posedge clk) begin
        if (!reset_n) deb_d <= RESET_VALUE;
        else          deb_d <= deb;
    end

    // Select which debounced transition counts as an event.
    always_comb begin
        ev = '0;
        if (EDGE_TYPE == 0)      ev = deb & ~deb_d;
        else if (EDGE_TYPE == 1) ev = ~deb & deb_d;
        else                     ev = deb ^ deb_d;
    end

    // Sticky capture with write-1-to-clear; a fresh event beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (!reset_n) edge_capture <= '0;
        else          edge_capture <= (edge_capture & ~clr) | ev;
    end

`ifdef PIO_IRQ_EN
    logic [WIDTH-1:0] irq_mask;

    // Interrupt mask register at address 1.
    always_ff @(posedge clk) begin
        if (!reset_n)                        irq_mask <= '0;
        else if (wr && bus.address == 2'd1)  irq_mask <= bus.writedata;
    end

    assign bus.irq = |(edge_capture & irq_mask);

    // Read mux, decoded from address alone.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = deb;
            2'd1:    bus.readdata = irq_mask;
            2'd3:    bus.readdata = edge_capture;
            default: bus.readdata = '0;
        endcase
    end
`else
    assign bus.irq = 1'b0;

    // Read mux, decoded from address alone; no mask register in this build.
    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0:    bus.readdata = deb;
            2'd3:    bus.readdata = edge_capture;
            default: bus.readdata = '0;
        endcase
    end
`endif

endmodule
